// File: rtl/seq_tx_pkg.sv
// Shared types and default parameter values for the repeating serial pattern transmitter.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } seq_state_e;

  localparam int   DEF_PAT_W    = 8;
  localparam int   DEF_CNT_W    = 4;
  localparam int   DEF_GAP_LEN  = 1;
  localparam logic DEF_IDLE_BIT = 1'b0;

  // Width of a counter that must hold values 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_tx_shifter.sv
// Parallel-load MSB-first shift register with a bit counter and a last-bit flag.
module seq_tx_shifter
  import seq_tx_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] load_data,
  output logic             msb,
  output logic             last
);

  localparam int BIT_W = cnt_width(PAT_W);

  logic [PAT_W-1:0] sr_q, sr_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    if (load) begin
      sr_d      = load_data;
      bit_cnt_d = '0;
    end else if (shift) begin
      sr_d      = {sr_q[PAT_W-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign msb  = sr_q[PAT_W-1];
  assign last = (bit_cnt_q == BIT_W'(PAT_W - 1));

endmodule

// File: rtl/seq_pattern_tx.sv
// Serializes a captured pattern MSB-first, repeating it s_repeat+1 times with idle gaps between copies.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int   PAT_W    = DEF_PAT_W,
  parameter int   CNT_W    = DEF_CNT_W,
  parameter int   GAP_LEN  = DEF_GAP_LEN,
  parameter logic IDLE_BIT = DEF_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PAT_W-1:0] s_data,
  input  logic [CNT_W-1:0] s_repeat,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             tx,
  output logic             tx_valid,
  output logic             busy,
  output logic             done
);

  localparam int GAP_W = cnt_width(GAP_LEN);

  seq_state_e       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             done_q, done_d;

  logic             load, shift, msb, last;
  logic [PAT_W-1:0] load_data;

  seq_tx_shifter #(.PAT_W(PAT_W)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .shift     (shift),
    .load_data (load_data),
    .msb       (msb),
    .last      (last)
  );

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    rep_d     = rep_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    load_data = pat_q;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          pat_d     = s_data;
          rep_d     = s_repeat;
          load      = 1'b1;
          load_data = s_data;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (!last) begin
          shift = 1'b1;
        end else if (rep_q != '0) begin
          // A copy just finished and more remain: gap first, or reload in place when gapless.
          rep_d = rep_q - 1'b1;
          if (GAP_LEN > 0) begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end else begin
            load = 1'b1;
          end
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        if (int'(gap_cnt_q) == GAP_LEN - 1) begin
          state_d = SHIFT;
          load    = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      rep_q     <= '0;
      gap_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      rep_q     <= rep_d;
      gap_cnt_q <= gap_cnt_d;
      done_q    <= done_d;
    end
  end

  // Outputs decode straight from flops, so reset forces the idle line level without a clock edge.
  assign s_ready  = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign tx_valid = (state_q == SHIFT);
  assign tx       = tx_valid ? msb : IDLE_BIT;
  assign done     = done_q;

endmodule
